// File: rtl/calc_op_sequencer.sv
// Calculator operation sequencer: op select, operand/dimension entry, ALU and printer handshakes.
// Optional CALC_REPEAT_EN: confirm in DONE re-runs the last op with the latched operands.
module calc_op_sequencer #(
    parameter int                       NUM_OPS      = 5,
    parameter int                       ID_W         = 5,
    parameter int                       NUM_IDS      = 20,
    parameter int                       DIM_W        = 3,
    parameter int                       MAX_DIM      = 5,
    parameter logic [2*NUM_OPS-1:0]     OPND_CNT     = {2'd1, 2'd1, 2'd1, 2'd2, 2'd2},
    parameter logic [NUM_OPS-1:0]       SCALAR_MASK  = 5'b00100,
    parameter logic [NUM_OPS-1:0]       NOPRINT_MASK = 5'b00001,
    parameter int                       ERR_TICKS    = 500_000_000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_en,
    input  logic [NUM_OPS-1:0]           op_sel,
    input  logic [7:0]                   scalar_sw,
    input  logic                         btn_confirm,
    input  logic                         btn_esc,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_done,
    output logic                         disp_req_en,
    output logic [1:0]                   disp_req_cmd,
    output logic [DIM_W-1:0]             disp_req_m,
    output logic [DIM_W-1:0]             disp_req_n,
    input  logic                         disp_req_done,
    output logic                         alu_start,
    output logic [$clog2(NUM_OPS)-1:0]   alu_op,
    output logic [3*ID_W-1:0]            alu_ids,
    output logic [7:0]                   alu_scalar,
    input  logic                         alu_done,
    input  logic                         alu_err,
    output logic                         prn_start,
    input  logic                         prn_done,
    output logic [1:0]                   opnd_idx,
    output logic                         rx_reject,
    output logic                         busy,
    output logic                         calc_done,
    output logic                         calc_err
);

    localparam int OPW = $clog2(NUM_OPS);
    localparam int TW  = $clog2(ERR_TICKS + 1);

    typedef enum logic [3:0] {
        IDLE, SEL_OP, SUM_REQ, SUM_WAIT, GET_M, GET_N, DET_REQ, DET_WAIT,
        GET_ID, SCALAR, ALU_GO, ALU_WAIT, ERR_HOLD, PRN_GO, PRN_WAIT, DONE
    } state_t;

    state_t           state;
    logic             conf_q;
    logic             esc_q;
    logic [DIM_W-1:0] m_q;
    logic [DIM_W-1:0] n_q;
    logic [TW-1:0]    timer;

    logic             esc_ev;
    logic             conf_ev;
    logic             rx_ev;
    logic [OPW-1:0]   sel_idx;
    logic [1:0]       op_cnt;
    logic             op_scalar;
    logic             op_noprint;
    logic             dim_ok;
    logic             id_ok;
    logic             more_opnd;
    logic             timer_last;
    logic [7:0]       scalar_val;

    assign esc_ev     = btn_esc & ~esc_q;
    assign conf_ev    = btn_confirm & ~conf_q & ~esc_ev;
    assign rx_ev      = rx_done & ~esc_ev;
    assign dim_ok     = (rx_data != 8'd0) && (rx_data <= 8'(MAX_DIM));
    assign id_ok      = rx_data < 8'(NUM_IDS);
    assign more_opnd  = ({1'b0, opnd_idx} + 3'd1) < {1'b0, op_cnt};
    assign timer_last = timer == TW'(ERR_TICKS - 1);
    assign scalar_val = scalar_sw[7] ? (8'd0 - {1'b0, scalar_sw[6:0]})
                                     : {1'b0, scalar_sw[6:0]};

    // Operand-count table lists op 0 in the leftmost field.
    always_comb begin
        sel_idx    = '0;
        op_cnt     = '0;
        op_scalar  = 1'b0;
        op_noprint = 1'b0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (op_sel[i]) sel_idx = OPW'(i);
        end
        for (int k = 0; k < NUM_OPS; k++) begin
            if (alu_op == OPW'(k)) begin
                op_cnt     = OPND_CNT[2*(NUM_OPS-1-k) +: 2];
                op_scalar  = SCALAR_MASK[k];
                op_noprint = NOPRINT_MASK[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            conf_q       <= 1'b0;
            esc_q        <= 1'b0;
            m_q          <= '0;
            n_q          <= '0;
            timer        <= '0;
            disp_req_en  <= 1'b0;
            disp_req_cmd <= '0;
            disp_req_m   <= '0;
            disp_req_n   <= '0;
            alu_start    <= 1'b0;
            alu_op       <= '0;
            alu_ids      <= '0;
            alu_scalar   <= '0;
            prn_start    <= 1'b0;
            opnd_idx     <= '0;
            rx_reject    <= 1'b0;
            busy         <= 1'b0;
            calc_done    <= 1'b0;
            calc_err     <= 1'b0;
        end else begin
            conf_q    <= btn_confirm;
            esc_q     <= btn_esc;
            alu_start <= 1'b0;
            prn_start <= 1'b0;
            rx_reject <= 1'b0;
            calc_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_en && !btn_confirm) begin
                        busy  <= 1'b1;
                        state <= SEL_OP;
                    end
                end
                SEL_OP: begin
                    if (esc_ev) begin
                        calc_done <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (conf_ev && (op_sel != '0)) begin
                        alu_op   <= sel_idx;
                        opnd_idx <= '0;
                        state    <= SUM_REQ;
                    end
                end
                SUM_REQ: begin
                    disp_req_en  <= 1'b1;
                    disp_req_cmd <= 2'd1;
                    disp_req_m   <= '0;
                    disp_req_n   <= '0;
                    state        <= SUM_WAIT;
                end
                SUM_WAIT: begin
                    if (disp_req_done) begin
                        disp_req_en <= 1'b0;
                        state       <= GET_M;
                    end
                end
                GET_M, GET_N, GET_ID: begin
                    if (esc_ev) begin
                        if (opnd_idx == 2'd0) begin
                            state <= SEL_OP;
                        end else begin
                            opnd_idx <= opnd_idx - 2'd1;
                            state    <= SUM_REQ;
                        end
                    end else if (rx_ev) begin
                        if (state == GET_ID) begin
                            if (!id_ok) begin
                                rx_reject <= 1'b1;
                            end else begin
                                alu_ids[opnd_idx*ID_W +: ID_W] <= rx_data[ID_W-1:0];
                                if (more_opnd) begin
                                    opnd_idx <= opnd_idx + 2'd1;
                                    state    <= SUM_REQ;
                                end else if (op_scalar) begin
                                    state <= SCALAR;
                                end else begin
                                    state <= ALU_GO;
                                end
                            end
                        end else if (!dim_ok) begin
                            rx_reject <= 1'b1;
                        end else if (state == GET_M) begin
                            m_q   <= rx_data[DIM_W-1:0];
                            state <= GET_N;
                        end else begin
                            n_q   <= rx_data[DIM_W-1:0];
                            state <= DET_REQ;
                        end
                    end
                end
                DET_REQ: begin
                    disp_req_en  <= 1'b1;
                    disp_req_cmd <= 2'd2;
                    disp_req_m   <= m_q;
                    disp_req_n   <= n_q;
                    state        <= DET_WAIT;
                end
                DET_WAIT: begin
                    if (disp_req_done) begin
                        disp_req_en <= 1'b0;
                        state       <= GET_ID;
                    end
                end
                SCALAR: begin
                    // Backing out of the scalar re-selects the last operand.
                    if (esc_ev) begin
                        state <= SUM_REQ;
                    end else if (conf_ev) begin
                        alu_scalar <= scalar_val;
                        state      <= ALU_GO;
                    end
                end
                ALU_GO: begin
                    alu_start <= 1'b1;
                    state     <= ALU_WAIT;
                end
                ALU_WAIT: begin
                    if (alu_err) begin
                        calc_err <= 1'b1;
                        timer    <= '0;
                        state    <= ERR_HOLD;
                    end else if (alu_done) begin
                        state <= op_noprint ? DONE : PRN_GO;
                    end
                end
                ERR_HOLD: begin
                    if (esc_ev || timer_last) begin
                        calc_err <= 1'b0;
                        state    <= SEL_OP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                PRN_GO: begin
                    prn_start <= 1'b1;
                    state     <= PRN_WAIT;
                end
                PRN_WAIT: begin
                    if (prn_done) state <= DONE;
                end
                DONE: begin
                    if (esc_ev) begin
                        state <= SEL_OP;
                    end else if (conf_ev) begin
`ifdef CALC_REPEAT_EN
                        alu_scalar <= scalar_val;
                        state      <= ALU_GO;
`else
                        state <= SEL_OP;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer with an ALU-start scoreboard.
module tb_calc_op_sequencer;

    localparam int NUM_OPS = 5;
    localparam int ID_W    = 5;
    localparam int DIM_W   = 3;
    localparam int OPW     = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start_en;
    logic [NUM_OPS-1:0] op_sel;
    logic [7:0]         scalar_sw;
    logic               btn_confirm;
    logic               btn_esc;
    logic [7:0]         rx_data;
    logic               rx_done;
    logic               disp_req_en;
    logic [1:0]         disp_req_cmd;
    logic [DIM_W-1:0]   disp_req_m;
    logic [DIM_W-1:0]   disp_req_n;
    logic               disp_req_done;
    logic               alu_start;
    logic [OPW-1:0]     alu_op;
    logic [3*ID_W-1:0]  alu_ids;
    logic [7:0]         alu_scalar;
    logic               alu_done;
    logic               alu_err;
    logic               prn_start;
    logic               prn_done;
    logic [1:0]         opnd_idx;
    logic               rx_reject;
    logic               busy;
    logic               calc_done;
    logic               calc_err;

    always #5 clk = ~clk;

    calc_op_sequencer #(.ERR_TICKS(16)) dut (
        .clk(clk), .rst_n(rst_n), .start_en(start_en), .op_sel(op_sel),
        .scalar_sw(scalar_sw), .btn_confirm(btn_confirm), .btn_esc(btn_esc),
        .rx_data(rx_data), .rx_done(rx_done),
        .disp_req_en(disp_req_en), .disp_req_cmd(disp_req_cmd),
        .disp_req_m(disp_req_m), .disp_req_n(disp_req_n),
        .disp_req_done(disp_req_done),
        .alu_start(alu_start), .alu_op(alu_op), .alu_ids(alu_ids),
        .alu_scalar(alu_scalar), .alu_done(alu_done), .alu_err(alu_err),
        .prn_start(prn_start), .prn_done(prn_done), .opnd_idx(opnd_idx),
        .rx_reject(rx_reject), .busy(busy), .calc_done(calc_done),
        .calc_err(calc_err)
    );

    typedef struct {
        logic [OPW-1:0]    op;
        logic [3*ID_W-1:0] ids;
        logic [7:0]        sc;
    } alu_exp_t;

    alu_exp_t exp_q[$];
    int checks  = 0;
    int errors  = 0;
    int alu_cnt = 0;
    int prn_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        alu_exp_t e;
        if (rst_n && alu_start) begin
            alu_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL alu_unexpected observed=start expected=none");
            end else begin
                e = exp_q.pop_front();
                chk("sb_alu_op", 32'(alu_op), 32'(e.op));
                chk("sb_alu_ids", 32'(alu_ids), 32'(e.ids));
                chk("sb_alu_scalar", 32'(alu_scalar), 32'(e.sc));
            end
        end
        if (rst_n && prn_start) prn_cnt++;
    end

    task automatic wait_out(input int sel, input string tag);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk);
            case (sel)
                0:       hit = alu_start;
                1:       hit = prn_start;
                default: hit = disp_req_en;
            endcase
        end
        chk({tag, "_seen"}, 32'(hit), 32'd1);
    endtask

    task automatic press(input logic c, input logic e);
        @(negedge clk);
        btn_confirm = c;
        btn_esc     = e;
        @(negedge clk);
        btn_confirm = 1'b0;
        btn_esc     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic rej, input string tag);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        chk(tag, 32'(rx_reject), 32'(rej));
        rx_done = 1'b0;
    endtask

    task automatic disp_hs(input logic [1:0] cmd, input int m, input int n, input string tag);
        wait_out(2, tag);
        chk({tag, "_cmd"}, 32'(disp_req_cmd), 32'(cmd));
        if (cmd == 2'd2) begin
            chk({tag, "_m"}, 32'(disp_req_m), 32'(m));
            chk({tag, "_n"}, 32'(disp_req_n), 32'(n));
        end
        disp_req_done = 1'b1;
        @(negedge clk);
        chk({tag, "_drop"}, 32'(disp_req_en), 32'd0);
        disp_req_done = 1'b0;
    endtask

    task automatic alu_ok();
        wait_out(0, "alu_start");
        alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
    endtask

    task automatic prn_ok();
        wait_out(1, "prn_start");
        prn_done = 1'b1;
        @(negedge clk);
        prn_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int a0;
        int p0;
        int cnt;
        rst_n = 1'b0; start_en = 1'b0; op_sel = '0; scalar_sw = '0;
        btn_confirm = 1'b0; btn_esc = 1'b0; rx_data = '0; rx_done = 1'b0;
        disp_req_done = 1'b0; alu_done = 1'b0; alu_err = 1'b0; prn_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_disp_en", 32'(disp_req_en), 32'd0);
        chk("rst_calc_err", 32'(calc_err), 32'd0);
        chk("rst_ids", 32'(alu_ids), 32'd0);
        chk("rst_scalar", 32'(alu_scalar), 32'd0);
        rst_n = 1'b1;

        // held confirm blocks leaving IDLE
        @(negedge clk);
        start_en = 1'b1; btn_confirm = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_hold_conf", 32'(busy), 32'd0);
        btn_confirm = 1'b0;
        @(negedge clk);
        chk("idle_start", 32'(busy), 32'd1);
        start_en = 1'b0;

        // esc beats confirm in SEL_OP
        op_sel = 5'b00001;
        @(negedge clk);
        btn_confirm = 1'b1; btn_esc = 1'b1;
        @(negedge clk);
        chk("esc_calc_done", 32'(calc_done), 32'd1);
        chk("esc_idle", 32'(busy), 32'd0);
        btn_confirm = 1'b0; btn_esc = 1'b0;
        @(negedge clk);
        chk("calc_done_pulse", 32'(calc_done), 32'd0);
        chk("esc_no_disp", 32'(disp_req_en), 32'd0);

        // two-operand op 4 through to the printer
        start_en = 1'b1;
        @(negedge clk);
        start_en = 1'b0;
        op_sel = '0;
        press(1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("zero_op_ignored", 32'(disp_req_en), 32'd0);
        op_sel = 5'b10000;
        press(1'b1, 1'b0);
        disp_hs(2'd1, 0, 0, "sum0");
        chk("op4_latched", 32'(alu_op), 32'd4);
        send_byte(8'd0, 1'b1, "m_zero_rej");
        send_byte(8'd2, 1'b0, "m_ok");
        send_byte(8'd3, 1'b0, "n_ok");
        disp_hs(2'd2, 2, 3, "det0");
        send_byte(8'd4, 1'b0, "id0_ok");
        chk("opnd_inc", 32'(opnd_idx), 32'd1);
        disp_hs(2'd1, 0, 0, "sum1");
        send_byte(8'd2, 1'b0, "m1_ok");
        send_byte(8'd3, 1'b0, "n1_ok");
        disp_hs(2'd2, 2, 3, "det1");
        exp_q.push_back('{op: 3'd4, ids: {5'd0, 5'd7, 5'd4}, sc: 8'h00});
        a0 = alu_cnt;
        p0 = prn_cnt;
        send_byte(8'd7, 1'b0, "id1_ok");
        alu_ok();
        chk("alu_once", 32'(alu_cnt), 32'(a0 + 1));
        prn_ok();
        chk("prn_once", 32'(prn_cnt), 32'(p0 + 1));
`ifdef CALC_REPEAT_EN
        exp_q.push_back('{op: 3'd4, ids: {5'd0, 5'd7, 5'd4}, sc: 8'h00});
        press(1'b1, 1'b0);
        alu_ok();
        chk("repeat_alu", 32'(alu_cnt), 32'(a0 + 2));
        prn_ok();
        press(1'b0, 1'b1);
`else
        press(1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("no_repeat", 32'(alu_cnt), 32'(a0 + 1));
`endif

        // scalar op with priority select and rejected bytes
        op_sel = 5'b00110;
        press(1'b1, 1'b0);
        disp_hs(2'd1, 0, 0, "sum2");
        chk("op2_priority", 32'(alu_op), 32'd2);
        send_byte(8'd1, 1'b0, "m_min_ok");
        send_byte(8'd6, 1'b1, "n_over_rej");
        send_byte(8'd5, 1'b0, "n_max_ok");
        disp_hs(2'd2, 1, 5, "det2");
        send_byte(8'd20, 1'b1, "id_20_rej");
        @(negedge clk);
        chk("rej_one_cycle", 32'(rx_reject), 32'd0);
        send_byte(8'd3, 1'b0, "id_3_ok");
        scalar_sw = 8'h85;
        exp_q.push_back('{op: 3'd2, ids: {5'd0, 5'd7, 5'd3}, sc: 8'hFB});
        a0 = alu_cnt;
        press(1'b1, 1'b0);
        alu_ok();
        chk("scalar_alu_once", 32'(alu_cnt), 32'(a0 + 1));
        prn_ok();
        press(1'b0, 1'b1);

        // error hold: err beats done, 16-cycle hold, no printer
        op_sel = 5'b00100;
        press(1'b1, 1'b0);
        disp_hs(2'd1, 0, 0, "sum3");
        send_byte(8'd1, 1'b0, "m3_ok");
        send_byte(8'd1, 1'b0, "n3_ok");
        disp_hs(2'd2, 1, 1, "det3");
        send_byte(8'd19, 1'b0, "id_19_ok");
        scalar_sw = 8'h80;
        exp_q.push_back('{op: 3'd2, ids: {5'd0, 5'd7, 5'd19}, sc: 8'h00});
        press(1'b1, 1'b0);
        wait_out(0, "alu_start_err");
        p0 = prn_cnt;
        alu_err = 1'b1; alu_done = 1'b1;
        @(negedge clk);
        alu_err = 1'b0; alu_done = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!calc_err) break;
            cnt++;
            @(negedge clk);
        end
        chk("err_hold_len", 32'(cnt), 32'd16);
        repeat (3) @(negedge clk);
        chk("err_no_prn", 32'(prn_cnt), 32'(p0));
        chk("err_busy", 32'(busy), 32'd1);

        // esc back from operand 1, then async reset mid-handshake
        op_sel = 5'b01000;
        press(1'b1, 1'b0);
        disp_hs(2'd1, 0, 0, "sum4");
        send_byte(8'd1, 1'b0, "m4_ok");
        send_byte(8'd1, 1'b0, "n4_ok");
        disp_hs(2'd2, 1, 1, "det4");
        send_byte(8'd0, 1'b0, "id4_ok");
        disp_hs(2'd1, 0, 0, "sum5");
        send_byte(8'd3, 1'b0, "m5_ok");
        press(1'b0, 1'b1);
        chk("esc_back_idx", 32'(opnd_idx), 32'd0);
        wait_out(2, "sum_again");
        chk("sum_again_cmd", 32'(disp_req_cmd), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_en", 32'(disp_req_en), 32'd0);
        chk("rst_async_busy", 32'(busy), 32'd0);
        chk("rst_async_ids", 32'(alu_ids), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // op 0 skips the printer
        @(negedge clk);
        start_en = 1'b1;
        @(negedge clk);
        start_en = 1'b0;
        op_sel = 5'b00001;
        press(1'b1, 1'b0);
        disp_hs(2'd1, 0, 0, "sum6");
        send_byte(8'd2, 1'b0, "m6_ok");
        send_byte(8'd2, 1'b0, "n6_ok");
        disp_hs(2'd2, 2, 2, "det6");
        exp_q.push_back('{op: 3'd0, ids: {5'd0, 5'd0, 5'd5}, sc: 8'h00});
        send_byte(8'd5, 1'b0, "id6_ok");
        p0 = prn_cnt;
        alu_ok();
        repeat (4) @(negedge clk);
        chk("noprint", 32'(prn_cnt), 32'(p0));
        press(1'b0, 1'b1);
        chk("done_esc_busy", 32'(busy), 32'd1);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
